// File: rtl/xinyi_debug_pkg.sv
// Shared types and constants for the debug writeback serializer.
//   wb_entry_t   : one retired register write {rd, wdata, pc}
//   WEN_ALL      : debug_wb_rf_wen value while an entry is emitted
//   IDLE_PC      : debug_wb_pc value on idle cycles
//   fill_state_t : occupancy class derived from the FIFO count
package xinyi_debug_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] pc;
  } wb_entry_t;

  localparam logic [3:0]  WEN_ALL = 4'hf;
  localparam logic [31:0] IDLE_PC = 32'h0;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_NEAR_FULL,
    FILL_FULL
  } fill_state_t;

  // NEAR_FULL is checked before EMPTY so a threshold >= depth still stalls.
  function automatic fill_state_t fill_state(input int unsigned cnt,
                                             input int unsigned depth,
                                             input int unsigned th);
    if (cnt >= depth)         return FILL_FULL;
    if ((depth - cnt) <= th)  return FILL_NEAR_FULL;
    if (cnt == 0)             return FILL_EMPTY;
    return FILL_PARTIAL;
  endfunction

endpackage

// File: rtl/debug_wb_serializer_fifo.sv
// wb_trace_fifo: 2-write / 1-read circular buffer of wb_entry_t.
//   clock, reset        : clock, asynchronous active-high reset
//   wr_cnt[1:0]         : number of entries offered this cycle (0..2)
//   wr_data0/wr_data1   : offered entries, wr_data0 is older
//   rd_en               : pop the head this cycle (ignored when empty)
//   rd_data             : current head entry
//   count               : registered occupancy, $clog2(DEPTH)+1 bits
//   accepted[1:0]       : entries actually written; older entries win
module wb_trace_fifo
  import xinyi_debug_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    wr_cnt,
  input  wb_entry_t     wr_data0,
  input  wb_entry_t     wr_data1,
  input  logic          rd_en,
  output wb_entry_t     rd_data,
  output logic [CW-1:0] count,
  output logic [1:0]    accepted
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   cap;
  logic          rd_fire;
  wb_entry_t     mem_q [DEPTH];

  always_comb begin
    rd_fire  = rd_en && (count_q != '0);
    // A same-cycle pop frees one slot for the incoming writes.
    cap      = {1'b0, CW'(DEPTH) - count_q} + {{CW{1'b0}}, rd_fire};
    accepted = 2'd0;
    if (cap >= (CW + 1)'(2)) begin
      accepted = (wr_cnt > 2'd2) ? 2'd2 : wr_cnt;
    end else if (cap == (CW + 1)'(1)) begin
      accepted = (wr_cnt != 2'd0) ? 2'd1 : 2'd0;
    end
    wr_ptr_nx = wr_ptr_q + AW'(1);
    wr_ptr_d  = wr_ptr_q + AW'(accepted);
    rd_ptr_d  = rd_ptr_q + AW'(rd_fire);
    count_d   = count_q + CW'(accepted) - CW'(rd_fire);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (accepted != 2'd0) mem_q[wr_ptr_q]  <= wr_data0;
    if (accepted == 2'd2) mem_q[wr_ptr_nx] <= wr_data1;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/debug_wb_serializer.sv
// debug_wb_serializer: serialises up to two retired register writes per
// cycle onto the single-commit debug_wb_* trace interface, in program order.
//   clock, reset            : clock, asynchronous active-high reset
//   wb{0,1}_en/rd/data/pc   : retired writes, slot 0 older than slot 1
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata : registered emitted write, 0 idle
//   stall_req               : core must not retire next cycle
//   overflow_err            : sticky, a qualifying write was dropped
// Optional (macro XINYI_COMMIT_CNT_EN):
//   commit_cnt[31:0]        : emitted entries
//   dual_cnt[31:0]          : cycles with two accepted pushes
module debug_wb_serializer
  import xinyi_debug_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned STALL_TH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb0_en,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  input  logic [31:0] wb0_pc,
  input  logic        wb1_en,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  input  logic [31:0] wb1_pc,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        stall_req,
  output logic        overflow_err
`ifdef XINYI_COMMIT_CNT_EN
  ,
  output logic [31:0] commit_cnt,
  output logic [31:0] dual_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          q0, q1, bypass, rd_en, emit;
  logic [1:0]    n_req, wr_cnt, accepted;
  logic [CW-1:0] count;
  wb_entry_t     e0, e1, first, head, emit_entry, wr_data0, wr_data1;
  fill_state_t   fill;

  logic [31:0] out_pc_q, out_pc_d;
  logic [3:0]  out_wen_q, out_wen_d;
  logic [4:0]  out_wnum_q, out_wnum_d;
  logic [31:0] out_wdata_q, out_wdata_d;
  logic        overflow_q, overflow_d;

  wb_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .wr_cnt   (wr_cnt),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .rd_en    (rd_en),
    .rd_data  (head),
    .count    (count),
    .accepted (accepted)
  );

  always_comb begin
    q0       = wb0_en && (wb0_rd != 5'd0);
    q1       = wb1_en && (wb1_rd != 5'd0);
    e0.rd    = wb0_rd;
    e0.wdata = wb0_data;
    e0.pc    = wb0_pc;
    e1.rd    = wb1_rd;
    e1.wdata = wb1_data;
    e1.pc    = wb1_pc;
    n_req    = {1'b0, q0} + {1'b0, q1};
    first    = q0 ? e0 : e1;
    rd_en    = (count != '0);

    // With an empty FIFO the oldest incoming entry goes straight to the
    // output register, giving one-cycle latency; only the rest is stored.
    bypass = (count == '0) && (n_req != 2'd0);
    if (bypass) begin
      wr_cnt   = n_req - 2'd1;
      wr_data0 = e1;
      wr_data1 = e1;
    end else begin
      wr_cnt   = n_req;
      wr_data0 = first;
      wr_data1 = e1;
    end

    overflow_d = overflow_q | (accepted != wr_cnt);

    emit        = bypass | rd_en;
    emit_entry  = bypass ? first : head;
    out_pc_d    = emit ? emit_entry.pc    : IDLE_PC;
    out_wen_d   = emit ? WEN_ALL          : '0;
    out_wnum_d  = emit ? emit_entry.rd    : '0;
    out_wdata_d = emit ? emit_entry.wdata : '0;

    fill      = fill_state(32'(count), DEPTH, STALL_TH);
    stall_req = (fill == FILL_NEAR_FULL) || (fill == FILL_FULL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_pc_q    <= '0;
      out_wen_q   <= '0;
      out_wnum_q  <= '0;
      out_wdata_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_pc_q    <= out_pc_d;
      out_wen_q   <= out_wen_d;
      out_wnum_q  <= out_wnum_d;
      out_wdata_q <= out_wdata_d;
      overflow_q  <= overflow_d;
    end
  end

  assign debug_wb_pc       = out_pc_q;
  assign debug_wb_rf_wen   = out_wen_q;
  assign debug_wb_rf_wnum  = out_wnum_q;
  assign debug_wb_rf_wdata = out_wdata_q;
  assign overflow_err      = overflow_q;

`ifdef XINYI_COMMIT_CNT_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] dual_cnt_q, dual_cnt_d;
  logic        both_accepted;

  always_comb begin
    // In bypass one entry skips the FIFO, so one stored entry means two taken.
    both_accepted = bypass ? ((n_req == 2'd2) && (accepted == 2'd1))
                           : (accepted == 2'd2);
    commit_cnt_d  = commit_cnt_q + 32'(emit);
    dual_cnt_d    = dual_cnt_q + 32'(both_accepted);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      commit_cnt_q <= '0;
      dual_cnt_q   <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      dual_cnt_q   <= dual_cnt_d;
    end
  end

  assign commit_cnt = commit_cnt_q;
  assign dual_cnt   = dual_cnt_q;
`endif

endmodule

// File: tb/tb_debug_wb_serializer.sv
module tb_debug_wb_serializer;

  localparam int DEPTH    = 8;
  localparam int STALL_TH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb0_en = 1'b0, wb1_en = 1'b0;
  logic [4:0]  wb0_rd = '0, wb1_rd = '0;
  logic [31:0] wb0_data = '0, wb1_data = '0, wb0_pc = '0, wb1_pc = '0;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic        stall_req, overflow_err;
`ifdef XINYI_COMMIT_CNT_EN
  logic [31:0] commit_cnt, dual_cnt;
`endif

  debug_wb_serializer #(.DEPTH(DEPTH), .STALL_TH(STALL_TH)) dut (
    .clock             (clock),
    .reset             (reset),
    .wb0_en            (wb0_en),
    .wb0_rd            (wb0_rd),
    .wb0_data          (wb0_data),
    .wb0_pc            (wb0_pc),
    .wb1_en            (wb1_en),
    .wb1_rd            (wb1_rd),
    .wb1_data          (wb1_data),
    .wb1_pc            (wb1_pc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .stall_req         (stall_req),
    .overflow_err      (overflow_err)
`ifdef XINYI_COMMIT_CNT_EN
    ,
    .commit_cnt        (commit_cnt),
    .dual_cnt          (dual_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the trace is simply every qualifying write in program order.
  // Writes are appended to a pending list (dropped if the list would exceed
  // DEPTH entries after this cycle's emission), and each cycle the oldest
  // pending write is emitted.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  ent_t exp_ent;
  bit   exp_valid = 0;
  bit   exp_ovf   = 0;
  int   exp_commit = 0;
  int   exp_dual   = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_valid  = 0;
      exp_ovf    = 0;
      exp_commit = 0;
      exp_dual   = 0;
    end else begin
      int taken;
      taken = 0;
      if (wb0_en && wb0_rd != 0) begin
        if (mq.size() < DEPTH + 1) begin mq.push_back('{wb0_rd, wb0_data, wb0_pc}); taken++; end
        else exp_ovf = 1;
      end
      if (wb1_en && wb1_rd != 0) begin
        if (mq.size() < DEPTH + 1) begin mq.push_back('{wb1_rd, wb1_data, wb1_pc}); taken++; end
        else exp_ovf = 1;
      end
      if (taken == 2) exp_dual++;
      if (mq.size() != 0) begin
        exp_ent   = mq.pop_front();
        exp_valid = 1;
        exp_commit++;
      end else begin
        exp_valid = 0;
      end
    end
  end

  always @(negedge clock) begin
    chk("pc",    debug_wb_pc,               exp_valid ? exp_ent.pc   : 32'h0);
    chk("wen",   32'(debug_wb_rf_wen),      exp_valid ? 32'hf        : 32'h0);
    chk("wnum",  32'(debug_wb_rf_wnum),     exp_valid ? 32'(exp_ent.rd) : 32'h0);
    chk("wdata", debug_wb_rf_wdata,         exp_valid ? exp_ent.data : 32'h0);
    chk("stall", 32'(stall_req),            32'((DEPTH - mq.size()) <= STALL_TH));
    chk("ovf",   32'(overflow_err),         32'(exp_ovf));
`ifdef XINYI_COMMIT_CNT_EN
    chk("commit_cnt", commit_cnt, 32'(exp_commit));
    chk("dual_cnt",   dual_cnt,   32'(exp_dual));
`endif
  end

  task automatic set_wb(input logic e0, input logic [4:0] r0, input logic [31:0] d0, input logic [31:0] p0,
                        input logic e1, input logic [4:0] r1, input logic [31:0] d1, input logic [31:0] p1);
    wb0_en = e0; wb0_rd = r0; wb0_data = d0; wb0_pc = p0;
    wb1_en = e1; wb1_rd = r1; wb1_data = d1; wb1_pc = p1;
  endtask

  task automatic idle();
    set_wb(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int emitted;
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("reset_stall", 32'(stall_req), 32'h0);
    reset = 1'b0;
    tick();

    // 1: single write, one-cycle latency then idle
    set_wb(1, 5'd5, 32'h1234, 32'hbfc00000, 0, 0, 0, 0);
    tick();
    chk("t1_wen",   32'(debug_wb_rf_wen), 32'hf);
    chk("t1_wnum",  32'(debug_wb_rf_wnum), 32'd5);
    chk("t1_wdata", debug_wb_rf_wdata, 32'h1234);
    chk("t1_pc",    debug_wb_pc, 32'hbfc00000);
    idle();
    tick();
    chk("t1_idle_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("t1_idle_pc",  debug_wb_pc, 32'h0);

    // 2: dual write keeps program order
    set_wb(1, 5'd1, 32'h11, 32'hbfc00010, 1, 5'd2, 32'h22, 32'hbfc00014);
    tick();
    chk("t2_pc0", debug_wb_pc, 32'hbfc00010);
    idle();
    tick();
    chk("t2_pc1", debug_wb_pc, 32'hbfc00014);
    chk("t2_wnum1", 32'(debug_wb_rf_wnum), 32'd2);
    tick();
    chk("t2_idle", 32'(debug_wb_rf_wen), 32'h0);

    // 3: filter, rd 0 never emits; slot 1 alone; slot 1 with rd 0
    set_wb(1, 5'd0, 32'hdead, 32'hbfc00020, 0, 5'd9, 32'h99, 32'hbfc00024);
    tick();
    chk("t3_filter_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("t3_filter_stall", 32'(stall_req), 32'h0);
    set_wb(0, 5'd4, 32'h44, 32'hbfc00030, 1, 5'd7, 32'h77, 32'hbfc00034);
    tick();
    chk("t3_slot1_wnum", 32'(debug_wb_rf_wnum), 32'd7);
    set_wb(1, 5'd3, 32'h33, 32'hbfc00040, 1, 5'd0, 32'hbad, 32'hbfc00044);
    tick();
    chk("t3_slot0_pc", debug_wb_pc, 32'hbfc00040);
    idle();
    tick();
    chk("t3_rd0_dropped", 32'(debug_wb_rf_wen), 32'h0);

    // 4: burst honouring stall_req
    for (int i = 0; i < 6; i++) begin
      if (stall_req) idle();
      else set_wb(1, 5'(2 * i + 1), 32'h400 + 32'(i), 32'h80000000 + 32'(8 * i),
                  1, 5'(2 * i + 2), 32'h500 + 32'(i), 32'h80000004 + 32'(8 * i));
      tick();
    end
    chk("t4_stall_high", 32'(stall_req), 32'h1);
    chk("t4_no_ovf", 32'(overflow_err), 32'h0);
    idle();
    repeat (7) tick();
    chk("t4_drained_stall", 32'(stall_req), 32'h0);
    chk("t4_drained_wen", 32'(debug_wb_rf_wen), 32'h0);

    // 5: overflow ignoring stall_req: 18 of 20 writes survive
    emitted = 0;
    for (int i = 0; i < 10; i++) begin
      set_wb(1, 5'(i + 1), 32'h600 + 32'(i), 32'h90000000 + 32'(8 * i),
             1, 5'(i + 11), 32'h700 + 32'(i), 32'h90000004 + 32'(8 * i));
      tick();
      if (debug_wb_rf_wen == 4'hf) emitted++;
    end
    chk("t5_ovf", 32'(overflow_err), 32'h1);
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (debug_wb_rf_wen == 4'hf) emitted++;
    end
    chk("t5_emitted", 32'(emitted), 32'd18);
    chk("t5_ovf_sticky", 32'(overflow_err), 32'h1);

    // 6: asynchronous reset with five entries pending
    for (int i = 0; i < 5; i++) begin
      set_wb(1, 5'(i + 1), 32'ha00 + 32'(i), 32'ha0000000 + 32'(8 * i),
             1, 5'(i + 20), 32'hb00 + 32'(i), 32'ha0000004 + 32'(8 * i));
      tick();
    end
    chk("t6_busy_wen", 32'(debug_wb_rf_wen), 32'hf);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_wen", 32'(debug_wb_rf_wen), 32'h0);
    chk("t6_async_pc", debug_wb_pc, 32'h0);
    chk("t6_async_ovf", 32'(overflow_err), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    emitted = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (debug_wb_rf_wen != 4'h0) emitted++;
    end
    chk("t6_no_stale", 32'(emitted), 32'd0);
    chk("t6_stall", 32'(stall_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
